cpu_data_arbiter: RTL

Sequences and arbitrates the internal sources that drive the 6502 data bus during CPU read cycles. It samples per-source claims (address-decode hits) at the rising edge of phi2, grants exactly one source, holds the grant through the hold window after phi2 falls, and enforces a bus turnaround gap before any later grant. Its `grant_o` feeds the `oe_i` vector of `cpu_data_mux`. Its `bus_oe_o` enables the data pad drivers.

---
 rtl/cpu_data_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cpu_data_arbiter.sv
// cpu_data_arbiter
//   Sequences and arbitrates the internal sources that drive the 6502 data
//   bus during CPU read cycles. Source claims are sampled at the rising edge
//   of phi2, and the lowest-index claimant is granted. The grant is held
//   through a HOLD window after phi2 falls. A TURNAROUND gap with no grant
//   then follows before the next grant is allowed.
//
// Parameters
//   COUNT      number of data sources (1..8)
//   HOLD       clocks the grant is kept after phi2 falls (0..15)
//   TURNAROUND idle clocks with no grant after HOLD (0..15)
//
// Ports
//   clk_i       system clock
//   rst_n_i     asynchronous active-low reset
//   phi2_i      CPU phi2, already synchronized to clk_i
//   cpu_rw_i    1 = read, 0 = write; sampled at phi2 rise
//   req_i       per-source claim for the current address
//   grant_o     one-hot or zero grant; feeds cpu_data_mux.oe_i
//   bus_oe_o    data pad output enable (= |grant_o)
//   conflict_o  sticky: multiple claims seen at a grant decision
//   late_o      sticky: phi2 rose during HOLD or TURN
//   err_clr_i   synchronous clear of conflict_o / late_o (a set event wins)
module cpu_data_arbiter #(
  parameter int unsigned COUNT      = 3,
  parameter int unsigned HOLD       = 2,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             phi2_i,
  input  logic             cpu_rw_i,
  input  logic [COUNT-1:0] req_i,
  output logic [COUNT-1:0] grant_o,
  output logic             bus_oe_o,
  output logic             conflict_o,
  output logic             late_o,
  input  logic             err_clr_i
);

  localparam int unsigned MAXC = (HOLD > TURNAROUND) ? HOLD : TURNAROUND;
  localparam int unsigned CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_HOLD,
    S_TURN
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [COUNT-1:0] r_grant, w_grant_nxt;
  logic             r_phi2_q;
  logic             r_conflict, r_late;
  logic             w_conflict_set, w_late_set;
  logic             w_rise, w_fall;
  logic [COUNT-1:0] w_pick;
  logic             w_multi;

  assign w_rise = phi2_i & ~r_phi2_q;
  assign w_fall = ~phi2_i & r_phi2_q;

  // x & -x isolates the lowest set bit; x & (x-1) is nonzero iff 2+ bits set.
  assign w_pick  = req_i & (~req_i + COUNT'(1));
  assign w_multi = |(req_i & (req_i - COUNT'(1)));

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_grant_nxt    = r_grant;
    w_conflict_set = 1'b0;
    w_late_set     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        if (w_rise) begin
          w_conflict_set = w_multi;
          if (cpu_rw_i && (|req_i)) begin
            w_grant_nxt = w_pick;
            w_state_nxt = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        if (w_fall) begin
          if (HOLD > 0) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = CW'(HOLD - 1);
          end else begin
            // HOLD == 0: release on the fall itself.
            w_grant_nxt = '0;
            if (TURNAROUND > 0) begin
              w_state_nxt = S_TURN;
              w_cnt_nxt   = CW'(TURNAROUND - 1);
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      S_HOLD: begin
        w_late_set = w_rise;
        if (r_cnt == '0) begin
          w_grant_nxt = '0;
          if (TURNAROUND > 0) begin
            w_state_nxt = S_TURN;
            w_cnt_nxt   = CW'(TURNAROUND - 1);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_TURN: begin
        w_grant_nxt = '0;
        w_late_set  = w_rise;
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_phi2_q   <= 1'b0;
      r_conflict <= 1'b0;
      r_late     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_grant    <= w_grant_nxt;
      r_phi2_q   <= phi2_i;
      r_conflict <= w_conflict_set | (r_conflict & ~err_clr_i);
      r_late     <= w_late_set | (r_late & ~err_clr_i);
    end
  end

  assign grant_o    = r_grant;
  assign bus_oe_o   = |r_grant;
  assign conflict_o = r_conflict;
  assign late_o     = r_late;

  a_grant_onehot0: assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(r_grant));

endmodule
